fsm_flujo: RTL and testbench

Parametrised flow-control state machine for a bank of `NUM_CANALES` FIFOs. It watches per-channel FIFO status flags, issues registered `pausa`/`continua` back-pressure per channel with almost_full/almost_empty hysteresis, and latches sticky per-channel overflow errors. It holds low/high watermark values loaded during init and publishes them to the FIFOs. It sits between the FIFO bank and the upstream data sources.

---
 rtl/fsm_flujo_pkg.sv | 21 ++
 rtl/fsm_flujo_canal.sv | 101 ++++++++++
 rtl/fsm_flujo.sv | 104 ++++++++++
 tb/tb_fsm_flujo.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_flujo_pkg.sv
// Shared definitions for the fsm_flujo flow-control block: state encoding,
// state register width, overflow counter width and a small state helper.
package fsm_flujo_pkg;

    localparam int ESTADO_W   = 3;
    localparam int CONTADOR_W = 8;

    typedef enum logic [ESTADO_W-1:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } estado_e;

    // RESET and INIT are the "quiet" states: overflow events are ignored there.
    function automatic logic es_silencio(logic [ESTADO_W-1:0] e);
        return (e == ST_RESET) || (e == ST_INIT);
    endfunction

endpackage

// File: rtl/fsm_flujo_canal.sv
// canal_flujo: per-channel back-pressure slice. Owns pausa/continua with
// almost_full/almost_empty hysteresis, the sticky overflow error and, when
// FSM_FLUJO_CONTADOR_EN is defined, a saturating overflow counter.
// Outputs are computed from the FSM's next state so they change on the
// same edge as the state register.
module canal_flujo
    import fsm_flujo_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ESTADO_W-1:0]   estado_actual_i,
    input  logic [ESTADO_W-1:0]   estado_siguiente_i,
    input  logic                  almost_full_i,
    input  logic                  almost_empty_i,
    input  logic                  overflow_i,
`ifdef FSM_FLUJO_CONTADOR_EN
    output logic [CONTADOR_W-1:0] cuenta_o,
`endif
    output logic                  pausa_o,
    output logic                  continua_o,
    output logic                  error_full_o
);

    logic pausa_q, pausa_d;
    logic continua_q, continua_d;
    logic error_q, error_d;
    logic limpiar;
    logic evento_overflow;

    assign limpiar         = es_silencio(estado_siguiente_i);
    assign evento_overflow = overflow_i & ~es_silencio(estado_actual_i);

    // Next-value logic: clear on the way into RESET/INIT, force pause in ERROR,
    // otherwise apply hysteresis where a raised almost_full beats almost_empty.
    always_comb begin
        pausa_d    = pausa_q;
        continua_d = continua_q;
        error_d    = error_q;
        if (limpiar) begin
            pausa_d    = 1'b0;
            continua_d = 1'b0;
            error_d    = 1'b0;
        end else begin
            error_d = error_q | evento_overflow;
            if (estado_siguiente_i == ST_ERROR) begin
                pausa_d    = 1'b1;
                continua_d = 1'b0;
            end else begin
                if (almost_full_i) begin
                    pausa_d = 1'b1;
                end else if (almost_empty_i) begin
                    pausa_d = 1'b0;
                end
                continua_d = ~pausa_d & ~error_d;
            end
        end
    end

    // Registered per-channel outputs, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pausa_q    <= 1'b0;
            continua_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            pausa_q    <= pausa_d;
            continua_q <= continua_d;
            error_q    <= error_d;
        end
    end

    assign pausa_o      = pausa_q;
    assign continua_o   = continua_q;
    assign error_full_o = error_q;

`ifdef FSM_FLUJO_CONTADOR_EN
    logic [CONTADOR_W-1:0] cuenta_q, cuenta_d;

    // Saturating count of overflow cycles; cleared together with the error flag.
    always_comb begin
        cuenta_d = cuenta_q;
        if (limpiar) begin
            cuenta_d = '0;
        end else if (evento_overflow && (cuenta_q != {CONTADOR_W{1'b1}})) begin
            cuenta_d = cuenta_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign cuenta_o = cuenta_q;
`endif

endmodule

// File: rtl/fsm_flujo.sv
// fsm_flujo: flow-control FSM for a bank of FIFOs. Holds the global state,
// the watermark registers and one canal_flujo slice per channel.
// Optional feature macro: FSM_FLUJO_CONTADOR_EN adds cuenta_overflow,
// one saturating 8-bit overflow counter per channel.
module fsm_flujo
    import fsm_flujo_pkg::*;
#(
    parameter int NUM_CANALES = 4,
    parameter int UMBRAL_W    = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          init,
    input  logic [UMBRAL_W-1:0]           umbral_bajo_in,
    input  logic [UMBRAL_W-1:0]           umbral_alto_in,
    input  logic [NUM_CANALES-1:0]        almost_full,
    input  logic [NUM_CANALES-1:0]        almost_empty,
    input  logic [NUM_CANALES-1:0]        empty_fifo,
    input  logic [NUM_CANALES-1:0]        fifo_overflow,
    output logic [UMBRAL_W-1:0]           umbral_bajo_out,
    output logic [UMBRAL_W-1:0]           umbral_alto_out,
    output logic [NUM_CANALES-1:0]        pausa,
    output logic [NUM_CANALES-1:0]        continua,
    output logic [NUM_CANALES-1:0]        error_full,
`ifdef FSM_FLUJO_CONTADOR_EN
    output logic [NUM_CANALES*CONTADOR_W-1:0] cuenta_overflow,
`endif
    output logic                          idle,
    output logic [ESTADO_W-1:0]           estado
);

    estado_e               estado_q, estado_d;
    logic                  idle_q;
    logic [UMBRAL_W-1:0]   umbral_bajo_q, umbral_alto_q;

    // Next-state logic: init wins everywhere except RESET, then overflow, then empty.
    always_comb begin
        estado_d = ST_RESET;
        case (estado_q)
            ST_RESET:  estado_d = ST_INIT;
            ST_INIT:   estado_d = init ? ST_INIT : ST_IDLE;
            ST_IDLE,
            ST_ACTIVE: begin
                if (init) begin
                    estado_d = ST_INIT;
                end else if (|fifo_overflow) begin
                    estado_d = ST_ERROR;
                end else if (&empty_fifo) begin
                    estado_d = ST_IDLE;
                end else begin
                    estado_d = ST_ACTIVE;
                end
            end
            ST_ERROR:  estado_d = init ? ST_INIT : ST_ERROR;
            default:   estado_d = ST_RESET;
        endcase
    end

    // State register with a registered idle flag that tracks the new state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= ST_RESET;
            idle_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            idle_q   <= (estado_d == ST_IDLE);
        end
    end

    // Watermarks follow the inputs every cycle spent in INIT, kept verbatim.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            umbral_bajo_q <= '0;
            umbral_alto_q <= '0;
        end else if (estado_q == ST_INIT) begin
            umbral_bajo_q <= umbral_bajo_in;
            umbral_alto_q <= umbral_alto_in;
        end
    end

    assign estado          = estado_q;
    assign idle            = idle_q;
    assign umbral_bajo_out = umbral_bajo_q;
    assign umbral_alto_out = umbral_alto_q;

    for (genvar g = 0; g < NUM_CANALES; g++) begin : g_canal
        canal_flujo u_canal (
            .clk                (clk),
            .reset              (reset),
            .estado_actual_i    (estado_q),
            .estado_siguiente_i (estado_d),
            .almost_full_i      (almost_full[g]),
            .almost_empty_i     (almost_empty[g]),
            .overflow_i         (fifo_overflow[g]),
`ifdef FSM_FLUJO_CONTADOR_EN
            .cuenta_o           (cuenta_overflow[g*CONTADOR_W +: CONTADOR_W]),
`endif
            .pausa_o            (pausa[g]),
            .continua_o         (continua[g]),
            .error_full_o       (error_full[g])
        );
    end

endmodule

// File: tb/tb_fsm_flujo.sv
// Testbench for fsm_flujo: directed scenarios plus randomized traffic checked
// against a behavioural model of the flow-control rules.
module tb_fsm_flujo;

    localparam int NC = 4;
    localparam int UW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          init;
    logic [UW-1:0] bajo_in, alto_in;
    logic [NC-1:0] af, ae, empty, ovf;
    logic [UW-1:0] bajo_out, alto_out;
    logic [NC-1:0] pausa, continua, error_full;
    logic          idle;
    logic [2:0]    estado;
`ifdef FSM_FLUJO_CONTADOR_EN
    logic [NC*8-1:0] cuenta_overflow;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model state
    int            m_estado;
    logic [NC-1:0] m_pausa, m_cont, m_err;
    logic [UW-1:0] m_bajo, m_alto;
    logic          m_idle;
    int            m_cuenta [NC];

    fsm_flujo #(.NUM_CANALES(NC), .UMBRAL_W(UW)) dut (
        .clk             (clk),
        .reset           (reset),
        .init            (init),
        .umbral_bajo_in  (bajo_in),
        .umbral_alto_in  (alto_in),
        .almost_full     (af),
        .almost_empty    (ae),
        .empty_fifo      (empty),
        .fifo_overflow   (ovf),
        .umbral_bajo_out (bajo_out),
        .umbral_alto_out (alto_out),
        .pausa           (pausa),
        .continua        (continua),
        .error_full      (error_full),
`ifdef FSM_FLUJO_CONTADOR_EN
        .cuenta_overflow (cuenta_overflow),
`endif
        .idle            (idle),
        .estado          (estado)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_estado = 0;
        m_pausa  = '0;
        m_cont   = '0;
        m_err    = '0;
        m_bajo   = '0;
        m_alto   = '0;
        m_idle   = 1'b0;
        for (int i = 0; i < NC; i++) m_cuenta[i] = 0;
    endtask

    // One clock of the flow-control rules, using the inputs present at the edge.
    task automatic model_step();
        int   nxt;
        logic quiet;
        case (m_estado)
            0:       nxt = 1;
            1:       nxt = init ? 1 : 2;
            2, 3:    nxt = init ? 1 : (ovf != 0) ? 4 : (empty == {NC{1'b1}}) ? 2 : 3;
            4:       nxt = init ? 1 : 4;
            default: nxt = 0;
        endcase
        quiet = (m_estado <= 1);
        if (m_estado == 1) begin
            m_bajo = bajo_in;
            m_alto = alto_in;
        end
        if (nxt <= 1) begin
            m_pausa = '0;
            m_cont  = '0;
            m_err   = '0;
            for (int i = 0; i < NC; i++) m_cuenta[i] = 0;
        end else begin
            if (!quiet) begin
                m_err = m_err | ovf;
                for (int i = 0; i < NC; i++)
                    if (ovf[i] && m_cuenta[i] < 255) m_cuenta[i] = m_cuenta[i] + 1;
            end
            if (nxt == 4) begin
                m_pausa = '1;
                m_cont  = '0;
            end else begin
                m_pausa = (m_pausa & ~ae) | af;
                m_cont  = ~m_pausa & ~m_err;
            end
        end
        m_idle   = (nxt == 2);
        m_estado = nxt;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; init = 1'b1; bajo_in = 3'd2; alto_in = 3'd6;
        af = '0; ae = '0; empty = '1; ovf = '0;
        model_reset();
        #12;
        compared++;
        if (estado !== 3'd0) begin
            mismatched++; $display("[TB] FAIL reset_estado: got %0d expected 0", estado);
        end
        compared++;
        if ({pausa, continua, error_full, idle} !== '0) begin
            mismatched++; $display("[TB] FAIL reset_outputs: got %b expected 0", {pausa, continua, error_full, idle});
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        compared++;
        if (estado !== 3'd1 || {pausa, continua, error_full, idle} !== '0) begin
            mismatched++; $display("[TB] FAIL first_init: estado %0d outs %b expected 1 / 0", estado, {pausa, continua, error_full, idle});
        end
        tick();
        compared++;
        if (bajo_out !== 3'd2 || alto_out !== 3'd6) begin
            mismatched++; $display("[TB] FAIL watermarks: got %0d/%0d expected 2/6", bajo_out, alto_out);
        end
        init = 1'b0;
        tick();
        compared++;
        if (estado !== 3'd2 || idle !== 1'b1 || continua !== 4'hF || pausa !== 4'h0) begin
            mismatched++; $display("[TB] FAIL enter_idle: estado %0d idle %b cont %b pausa %b expected 2 1 1111 0000", estado, idle, continua, pausa);
        end
    endtask

    task automatic test_hysteresis();
        empty = 4'b1110;
        tick();
        compared++;
        if (estado !== 3'd3 || idle !== 1'b0) begin
            mismatched++; $display("[TB] FAIL to_active: estado %0d idle %b expected 3 0", estado, idle);
        end
        af = 4'b0010;
        tick();
        compared++;
        if (pausa !== 4'b0010 || continua !== 4'b1101) begin
            mismatched++; $display("[TB] FAIL pausa_set: pausa %b cont %b expected 0010 1101", pausa, continua);
        end
        af = 4'b0000;
        tick();
        compared++;
        if (pausa !== 4'b0010) begin
            mismatched++; $display("[TB] FAIL pausa_hold: got %b expected 0010", pausa);
        end
        ae = 4'b0010;
        tick();
        compared++;
        if (pausa !== 4'b0000 || continua !== 4'b1111) begin
            mismatched++; $display("[TB] FAIL pausa_clear: pausa %b cont %b expected 0000 1111", pausa, continua);
        end
        af = 4'b0100; ae = 4'b0100;
        tick();
        compared++;
        if (pausa !== 4'b0100 || continua !== 4'b1011) begin
            mismatched++; $display("[TB] FAIL set_wins: pausa %b cont %b expected 0100 1011", pausa, continua);
        end
        af = '0; ae = 4'b0100;
        tick();
    endtask

    task automatic test_overflow_error();
        ae = '0;
        af = 4'b0001;
        tick();
        af = '0;
        ovf = 4'b1000;
        tick();
        ovf = '0;
        compared++;
        if (error_full !== 4'b1000 || estado !== 3'd4 || pausa !== 4'hF || continua !== 4'h0) begin
            mismatched++; $display("[TB] FAIL overflow_error: err %b estado %0d pausa %b cont %b expected 1000 4 1111 0000", error_full, estado, pausa, continua);
        end
        tick();
        compared++;
        if (error_full !== 4'b1000 || estado !== 3'd4) begin
            mismatched++; $display("[TB] FAIL error_sticky: err %b estado %0d expected 1000 4", error_full, estado);
        end
        init = 1'b1;
        tick();
        compared++;
        if (estado !== 3'd1 || {error_full, pausa, continua} !== '0) begin
            mismatched++; $display("[TB] FAIL init_clear: estado %0d outs %b expected 1 0", estado, {error_full, pausa, continua});
        end
        init = 1'b0;
        tick();
        tick();
        compared++;
        if (estado !== 3'd3) begin
            mismatched++; $display("[TB] FAIL back_active: got %0d expected 3", estado);
        end
    endtask

    task automatic test_priority();
        ovf = 4'b0001; empty = 4'hF;
        tick();
        ovf = '0;
        compared++;
        if (estado !== 3'd4 || error_full !== 4'b0001) begin
            mismatched++; $display("[TB] FAIL ovf_over_empty: estado %0d err %b expected 4 0001", estado, error_full);
        end
        init = 1'b1;
        tick();
        init = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [NC-1:0] tmp;
        for (int c = 0; c < 400; c++) begin
            bajo_in = UW'($urandom());
            alto_in = UW'($urandom());
            af      = ($urandom_range(0, 2) == 0) ? NC'($urandom()) : '0;
            ae      = ($urandom_range(0, 2) == 0) ? NC'($urandom()) : '0;
            empty   = ($urandom_range(0, 3) == 0) ? '1 : NC'($urandom());
            tmp     = NC'(1) << $urandom_range(0, NC - 1);
            ovf     = ($urandom_range(0, 24) == 0) ? tmp : '0;
            init    = ($urandom_range(0, 29) == 0);
            tick();
            compared++;
            if (estado !== 3'(m_estado) || idle !== m_idle) begin
                mismatched++; $display("[TB] FAIL rnd_estado c%0d: got %0d/%b expected %0d/%b", c, estado, idle, m_estado, m_idle);
            end
            compared++;
            if (pausa !== m_pausa || continua !== m_cont || error_full !== m_err) begin
                mismatched++; $display("[TB] FAIL rnd_canal c%0d: got %b %b %b expected %b %b %b", c, pausa, continua, error_full, m_pausa, m_cont, m_err);
            end
            compared++;
            if (bajo_out !== m_bajo || alto_out !== m_alto) begin
                mismatched++; $display("[TB] FAIL rnd_umbral c%0d: got %0d/%0d expected %0d/%0d", c, bajo_out, alto_out, m_bajo, m_alto);
            end
            compared++;
            if ((pausa & continua) !== '0) begin
                mismatched++; $display("[TB] FAIL rnd_exclusive c%0d: pausa %b cont %b expected no overlap", c, pausa, continua);
            end
`ifdef FSM_FLUJO_CONTADOR_EN
            for (int i = 0; i < NC; i++) begin
                compared++;
                if (cuenta_overflow[i*8 +: 8] !== 8'(m_cuenta[i])) begin
                    mismatched++; $display("[TB] FAIL rnd_cuenta%0d c%0d: got %0d expected %0d", i, c, cuenta_overflow[i*8 +: 8], m_cuenta[i]);
                end
            end
`endif
        end
        init = 1'b1; af = '0; ae = '0; ovf = '0;
        tick();
        init = 1'b0;
        tick();
    endtask

`ifdef FSM_FLUJO_CONTADOR_EN
    task automatic test_counter();
        empty = 4'b1110;
        tick();
        ovf = 4'b0100;
        for (int c = 0; c < 300; c++) tick();
        ovf = '0;
        compared++;
        if (cuenta_overflow[23:16] !== 8'd255 || cuenta_overflow[15:0] !== 16'd0 || cuenta_overflow[31:24] !== 8'd0) begin
            mismatched++; $display("[TB] FAIL cuenta_sat: got %h expected 00ff0000", cuenta_overflow);
        end
        init = 1'b1;
        tick();
        init = 1'b0;
        compared++;
        if (cuenta_overflow !== '0) begin
            mismatched++; $display("[TB] FAIL cuenta_clear: got %h expected 0", cuenta_overflow);
        end
        tick();
    endtask
`endif

    task automatic test_async_reset();
        init = 1'b1; bajo_in = 3'd5; alto_in = 3'd3;
        tick();
        init = 1'b0; empty = 4'b1110; af = 4'b0011;
        tick();
        af = '0;
        tick();
        ovf = 4'b0010;
        tick();
        ovf = '0;
        compared++;
        if (estado !== 3'd4 || error_full !== 4'b0010 || bajo_out !== 3'd5 || alto_out !== 3'd3) begin
            mismatched++; $display("[TB] FAIL pre_reset: estado %0d err %b umbral %0d/%0d expected 4 0010 5/3", estado, error_full, bajo_out, alto_out);
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compared++;
        if (estado !== 3'd0 || {pausa, continua, error_full, idle} !== '0 || {bajo_out, alto_out} !== '0) begin
            mismatched++; $display("[TB] FAIL async_reset: estado %0d outs %b umbral %0d/%0d expected all 0", estado, {pausa, continua, error_full, idle}, bajo_out, alto_out);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        compared++;
        if (estado !== 3'd1) begin
            mismatched++; $display("[TB] FAIL after_reset: got %0d expected 1", estado);
        end
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_hysteresis();
        test_overflow_error();
        test_priority();
        test_random();
`ifdef FSM_FLUJO_CONTADOR_EN
        test_counter();
`endif
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
